// File: rtl/rib_arb_pkg.sv
// Shared types and constants for the RIB bus arbiter.
package rib_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  // Master slots on the shared bus.
  localparam int M_JTAG = 0;
  localparam int M_EX   = 1;
  localparam int M_PC   = 2;
  localparam int M_UART = 3;
  localparam int NUM_MASTERS = M_UART + 1;

  // Round-robin successor over slots 1..last; slot 0 never takes part in the rotation.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned last);
    return (idx >= last) ? 32'd1 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rib_arb_ctrl_rr_pick.sv
// Combinational winner picker: slot 0 wins outright, others rotate from the pointer.
module rr_pick
  import rib_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  localparam int PW = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic             valid_o
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk slots starting at the pointer and grant the first requester found.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = ptr_i;
    if (req_i[M_JTAG]) begin
      gnt_o[M_JTAG] = 1'b1;
      found         = 1'b1;
    end
    for (int k = 0; k < NUM_M - 1; k++) begin
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = PW'(rr_next(32'(idx), NUM_M - 1));
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rib_arb_ctrl.sv
// Sequencing arbiter for the shared RIB slave bus: one master at a time, ack or timeout.
module rib_arb_ctrl
  import rib_arb_pkg::*;
#(
  parameter int NUM_M   = NUM_MASTERS,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [DW-1:0]       m_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic [DW-1:0]       s_rdata_i,
  input  logic                s_ack_i,
  output logic                hold_flag_o,
  output logic [NUM_M-1:0]    gnt_o
);

  localparam int PW = $clog2(NUM_M);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [NUM_M-1:0] pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    addr_arr  [NUM_M];
  logic [DW-1:0]    wdata_arr [NUM_M];
  logic             busy;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr_i[gi*AW +: AW];
    assign wdata_arr[gi] = m_wdata_i[gi*DW +: DW];
  end

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req_i   (m_req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // One-hot winner to index for request capture and pointer update.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_gnt[i]) win_idx = PW'(i);
    end
  end

  // State and capture registers; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack or timeout in BUSY, single-cycle DONE/ERR.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          we_d    = m_we_i[win_idx];
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          cnt_d   = '0;
          // JTAG wins by priority, so it does not move the rotation.
          if (!pick_gnt[M_JTAG]) ptr_d = PW'(rr_next(32'(win_idx), NUM_M - 1));
        end
      end
      BUSY: begin
        // An ack arriving on the timeout cycle still counts as success.
        if (s_ack_i) begin
          state_d = DONE;
          rdata_d = s_rdata_i;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == BUSY);
  assign s_req_o     = busy;
  assign s_we_o      = busy & we_q;
  assign s_addr_o    = busy ? addr_q : '0;
  assign s_wdata_o   = busy ? wdata_q : '0;
  assign m_ack_o     = (state_q == DONE) ? gnt_q : '0;
  assign m_err_o     = (state_q == ERR) ? gnt_q : '0;
  assign m_rdata_o   = ((state_q == DONE) && !we_q) ? rdata_q : '0;
  assign gnt_o       = gnt_q;
  assign hold_flag_o = (m_req_i[M_EX] & ~m_ack_o[M_EX] & ~m_err_o[M_EX]) |
                       (m_req_i[M_PC] & ~m_ack_o[M_PC] & ~m_err_o[M_PC]);

endmodule

// File: tb/tb_rib_arb_ctrl.sv
// Directed bench for rib_arb_ctrl with a response scoreboard.
module tb_rib_arb_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req_i, m_we_i;
  logic [127:0] m_addr_i, m_wdata_i;
  logic [3:0]   m_ack_o, m_err_o, gnt_o;
  logic [31:0]  m_rdata_o, s_addr_o, s_wdata_o, s_rdata_i;
  logic         s_req_o, s_we_o, s_ack_i, hold_flag_o;

  typedef struct {
    logic [3:0]  gnt;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   nreq;

  rib_arb_ctrl #(.NUM_M(4), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_wdata_i   (m_wdata_i),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .m_rdata_o   (m_rdata_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ack_i     (s_ack_i),
    .hold_flag_o (hold_flag_o),
    .gnt_o       (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_master(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m_we_i[i]             = we;
    m_addr_i[i*32 +: 32]  = addr;
    m_wdata_i[i*32 +: 32] = wd;
  endtask

  // Slave model: acks on the given BUSY cycle (0 = never); counts cycles with s_req_o high.
  task automatic run_cycles(input int n, input int ack_after, output int req_cycles);
    int bc;
    bc = 0;
    req_cycles = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (s_req_o) begin
        bc++;
        req_cycles++;
        s_ack_i = (ack_after != 0) && (bc == ack_after);
      end else begin
        bc = 0;
        s_ack_i = 1'b0;
      end
    end
  endtask

  // Response monitor: every ack/err pulse pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if ((m_ack_o != 4'b0) || (m_err_o != 4'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {m_ack_o, m_err_o}, 8'h00);
      end else begin
        e = sb.pop_front();
        $display("[TB] resp ack=%b err=%b rdata=%h", m_ack_o, m_err_o, m_rdata_o);
        check("ack_vec", m_ack_o, e.err ? 4'b0 : e.gnt);
        check("err_vec", m_err_o, e.err ? e.gnt : 4'b0);
        check("rdata", m_rdata_o, e.err ? 32'h0 : e.rdata);
      end
    end
  end

  initial begin
    rst = 1'b1; m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_rdata_i = '0; s_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_s_req", s_req_o, 1'b0);
    check("rst_gnt", gnt_o, 4'b0);
    check("rst_ack", m_ack_o, 4'b0);
    check("rst_err", m_err_o, 4'b0);
    check("rst_rdata", m_rdata_o, 32'h0);
    check("rst_hold", hold_flag_o, 1'b0);
    rst = 1'b0;
    tick();

    // Priority: JTAG keeps winning, then rotation 1,2,3,1.
    for (int i = 0; i < 4; i++) set_master(i, 1'b0, 32'h100 * i, 32'h0);
    s_rdata_i = 32'h0000_5A5A;
    m_req_i = 4'b1111;
    for (int i = 0; i < 3; i++) sb.push_back('{gnt: 4'b0001, err: 1'b0, rdata: 32'h5A5A});
    sb.push_back('{gnt: 4'b0010, err: 1'b0, rdata: 32'h5A5A});
    sb.push_back('{gnt: 4'b0100, err: 1'b0, rdata: 32'h5A5A});
    sb.push_back('{gnt: 4'b1000, err: 1'b0, rdata: 32'h5A5A});
    sb.push_back('{gnt: 4'b0010, err: 1'b0, rdata: 32'h5A5A});
    run_cycles(8, 1, nreq);
    m_req_i[0] = 1'b0;
    run_cycles(12, 1, nreq);
    m_req_i = 4'b0;
    run_cycles(2, 0, nreq);
    check("prio_idle_gnt", gnt_o, 4'b0);

    // Single read by core ex with ack on the second BUSY cycle.
    set_master(1, 1'b0, 32'h1000_0004, 32'h0);
    m_req_i = 4'b0010;
    sb.push_back('{gnt: 4'b0010, err: 1'b0, rdata: 32'hDEAD_BEEF});
    #1;
    check("rd_hold_idle", hold_flag_o, 1'b1);
    tick();
    check("rd_s_req1", s_req_o, 1'b1);
    check("rd_s_addr", s_addr_o, 32'h1000_0004);
    check("rd_s_we", s_we_o, 1'b0);
    check("rd_gnt", gnt_o, 4'b0010);
    check("rd_hold_busy", hold_flag_o, 1'b1);
    tick();
    check("rd_s_req2", s_req_o, 1'b1);
    s_ack_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
    tick();
    s_ack_i = 1'b0;
    check("rd_s_req_done", s_req_o, 1'b0);
    check("rd_hold_done", hold_flag_o, 1'b0);
    check("rd_rdata_done", m_rdata_o, 32'hDEAD_BEEF);
    m_req_i = 4'b0;
    tick();
    check("rd_gnt_idle", gnt_o, 4'b0);

    // Timeout: no ack, five BUSY cycles then an error pulse.
    set_master(3, 1'b1, 32'h3000_0000, 32'h5555_AAAA);
    m_req_i = 4'b1000;
    sb.push_back('{gnt: 4'b1000, err: 1'b1, rdata: 32'h0});
    run_cycles(6, 0, nreq);
    check("to_req_cycles", nreq, 5);
    check("to_err_now", m_err_o, 4'b1000);
    m_req_i = 4'b0;
    tick();
    check("to_gnt_idle", gnt_o, 4'b0);

    // Ack on the very cycle the counter reaches the limit: success wins.
    set_master(2, 1'b0, 32'h2000_0008, 32'h0);
    s_rdata_i = 32'hCAFE_0001;
    m_req_i = 4'b0100;
    sb.push_back('{gnt: 4'b0100, err: 1'b0, rdata: 32'hCAFE_0001});
    run_cycles(6, 5, nreq);
    check("race_req_cycles", nreq, 5);
    check("race_no_err", m_err_o, 4'b0);
    m_req_i = 4'b0;
    tick();

    // Reset in the middle of a transfer, then pointer must be back at 1.
    set_master(1, 1'b0, 32'h1000_0010, 32'h0);
    m_req_i = 4'b0010;
    tick();
    tick();
    check("mr_busy2", s_req_o, 1'b1);
    rst = 1'b1; m_req_i = 4'b0;
    tick();
    check("mr_s_req", s_req_o, 1'b0);
    check("mr_gnt", gnt_o, 4'b0);
    check("mr_ack", m_ack_o, 4'b0);
    check("mr_err", m_err_o, 4'b0);
    rst = 1'b0;
    tick();
    s_rdata_i = 32'h0000_0111;
    m_req_i = 4'b1110;
    sb.push_back('{gnt: 4'b0010, err: 1'b0, rdata: 32'h0000_0111});
    run_cycles(2, 1, nreq);
    m_req_i = 4'b0;
    run_cycles(1, 0, nreq);

    // Uart write: request dropped and inputs changed mid-transfer.
    set_master(3, 1'b1, 32'h2000_0010, 32'h1234_5678);
    m_req_i = 4'b1000;
    sb.push_back('{gnt: 4'b1000, err: 1'b0, rdata: 32'h0});
    tick();
    check("wr_s_we", s_we_o, 1'b1);
    check("wr_s_wdata1", s_wdata_o, 32'h1234_5678);
    check("wr_s_addr1", s_addr_o, 32'h2000_0010);
    set_master(3, 1'b0, 32'hFFFF_0000, 32'hFFFF_FFFF);
    m_req_i = 4'b0;
    tick();
    check("wr_s_req2", s_req_o, 1'b1);
    check("wr_s_wdata2", s_wdata_o, 32'h1234_5678);
    check("wr_s_addr2", s_addr_o, 32'h2000_0010);
    s_ack_i = 1'b1; s_rdata_i = 32'hBAD0_BAD0;
    tick();
    s_ack_i = 1'b0;
    check("wr_ack_now", m_ack_o, 4'b1000);
    tick();
    tick();

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
